vga_scanout: RTL and testbench

- Parametrised VGA scan-out engine running in the pixel clock domain.
- Generates programmable-timing HS/VS/BLANK and consumes a valid/ready RGB565 pixel stream, expanding each pixel to COLOR_W-bit DAC colour.
- Detects stream underflow and frame misalignment, then resynchronises on the next start-of-frame marker.
- Sits between the pixel FIFO read side and the ADV7123-style DAC pins.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_timing.sv | 74 +++++++
 rtl/vga_scanout.sv | 167 ++++++++++++++++
 tb/tb_vga_scanout.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared types and helpers for the VGA scan-out and timing blocks.
//   state_e        : scan-out stream state (IDLE, SEEK, LOCKED)
//   htotal/vtotal  : total pixels per line / lines per frame
//   rgb565_expand  : MSB-first replication of one RGB565 field to 16 bits;
//                    the caller keeps the top COLOR_W bits.
// ---------------------------------------------------------------------------
package vga_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEEK,
      ST_LOCKED
   } state_e;

   function automatic int htotal(input int hdisp, input int hfp,
                                 input int hpulse, input int hbp);
      return hdisp + hfp + hpulse + hbp;
   endfunction

   function automatic int vtotal(input int vdisp, input int vfp,
                                 input int vpulse, input int vbp);
      return vdisp + vfp + vpulse + vbp;
   endfunction

   // field holds the colour component right-aligned; width is its bit count
   // (5 for R/B, 6 for G). Bits are repeated MSB-first across all 16 bits.
   function automatic logic [15:0] rgb565_expand(input logic [5:0] field,
                                                 input int width);
      logic [15:0] res;
      res = '0;
      for (int i = 0; i < 16; i++) begin
         res[15-i] = field[width - 1 - (i % width)];
      end
      return res;
   endfunction

endpackage

// File: rtl/vga_timing.sv
// ---------------------------------------------------------------------------
// vga_timing
// Free-running raster counters with active-area / sync-pulse decode.
// Counters run whenever reset is low; all decode is from current values.
//   clk, rst  : clock, asynchronous active-high reset (raster back to 0,0)
//   active    : current position is inside the visible area
//   hs_pulse  : current column is inside the horizontal sync pulse
//   vs_pulse  : current line is inside the vertical sync pulse
//   origin    : current position is (0,0)
// ---------------------------------------------------------------------------
module vga_timing
   import vga_pkg::*;
#(
   parameter int HDISP  = 640,
   parameter int VDISP  = 480,
   parameter int HFP    = 16,
   parameter int HPULSE = 96,
   parameter int HBP    = 48,
   parameter int VFP    = 11,
   parameter int VPULSE = 2,
   parameter int VBP    = 31
) (
   input  logic clk,
   input  logic rst,
   output logic active,
   output logic hs_pulse,
   output logic vs_pulse,
   output logic origin
);

   localparam int HTOTAL = htotal(HDISP, HFP, HPULSE, HBP);
   localparam int VTOTAL = vtotal(VDISP, VFP, VPULSE, VBP);
   localparam int HW     = $clog2(HTOTAL);
   localparam int VW     = $clog2(VTOTAL);

   logic [HW-1:0] ct_h_q, ct_h_d;
   logic [VW-1:0] ct_v_q, ct_v_d;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      ct_h_d = ct_h_q + HW'(1);
      ct_v_d = ct_v_q;
      if (int'(ct_h_q) == HTOTAL - 1) begin
         ct_h_d = '0;
         if (int'(ct_v_q) == VTOTAL - 1) begin
            ct_v_d = '0;
         end else begin
            ct_v_d = ct_v_q + VW'(1);
         end
      end
   end

   // NOTE: flops use non-blocking assignment so every register samples the
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ct_h_q <= '0;
         ct_v_q <= '0;
      end else begin
         ct_h_q <= ct_h_d;
         ct_v_q <= ct_v_d;
      end
   end

   // Compare in int so a pulse ending exactly at the total cannot wrap.
   assign active   = (int'(ct_h_q) < HDISP) && (int'(ct_v_q) < VDISP);
   assign hs_pulse = (int'(ct_h_q) >= HDISP + HFP) &&
                     (int'(ct_h_q) <  HDISP + HFP + HPULSE);
   assign vs_pulse = (int'(ct_v_q) >= VDISP + VFP) &&
                     (int'(ct_v_q) <  VDISP + VFP + VPULSE);
   assign origin   = (ct_h_q == '0) && (ct_v_q == '0);

endmodule

// File: rtl/vga_scanout.sv
// ---------------------------------------------------------------------------
// vga_scanout
// VGA scan-out engine: programmable raster timing plus an RGB565 valid/ready
// stream expanded to COLOR_W-bit DAC colour (COLOR_W legal range 6..16).
// All VGA_* outputs are registered one cycle after the raster position they
// describe; a pixel accepted at (h,v) lands together with BLANK for (h,v).
//   CLK, RST       : pixel clock, asynchronous active-high reset
//   ENABLE         : scan-out enable; low returns the stream FSM to IDLE
//   PIX_DATA/SOF/VALID, PIX_READY : pixel stream handshake
//   VGA_HS/VS/BLANK/SYNC/R/G/B    : DAC and sync pins (BLANK is blank_n)
//   FRAME_START    : one-cycle pulse following raster origin
//   LOCKED         : stream aligned to raster
//   UNDERFLOW      : sticky, stream starved during an active pixel
//   MISALIGN       : sticky, SOF seen away from origin (or missing at origin)
//   ERR_CLR        : clears both sticky flags; a same-cycle set wins
// ---------------------------------------------------------------------------
module vga_scanout
   import vga_pkg::*;
#(
   parameter int HDISP   = 640,
   parameter int VDISP   = 480,
   parameter int HFP     = 16,
   parameter int HPULSE  = 96,
   parameter int HBP     = 48,
   parameter int VFP     = 11,
   parameter int VPULSE  = 2,
   parameter int VBP     = 31,
   parameter bit HS_POL  = 1'b0,
   parameter bit VS_POL  = 1'b0,
   parameter int COLOR_W = 10
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic               ENABLE,
   input  logic [15:0]        PIX_DATA,
   input  logic               PIX_SOF,
   input  logic               PIX_VALID,
   output logic               PIX_READY,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic [COLOR_W-1:0] VGA_R,
   output logic [COLOR_W-1:0] VGA_G,
   output logic [COLOR_W-1:0] VGA_B,
   output logic               FRAME_START,
   output logic               LOCKED,
   output logic               UNDERFLOW,
   output logic               MISALIGN,
   input  logic               ERR_CLR
);

   logic active, hs_pulse, vs_pulse, origin;

   vga_timing #(
      .HDISP (HDISP),  .VDISP (VDISP),
      .HFP   (HFP),    .HPULSE(HPULSE), .HBP(HBP),
      .VFP   (VFP),    .VPULSE(VPULSE), .VBP(VBP)
   ) u_timing (
      .clk     (CLK),
      .rst     (RST),
      .active  (active),
      .hs_pulse(hs_pulse),
      .vs_pulse(vs_pulse),
      .origin  (origin)
   );

   state_e             state_q, state_d;
   logic               hs_q, hs_d, vs_q, vs_d;
   logic               blank_q, blank_d, frame_start_q, frame_start_d;
   logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
   logic               underflow_q, underflow_d, misalign_q, misalign_d;
   logic               pix_ready, show, underflow_set, misalign_set;

   always_comb begin
      state_d       = state_q;
      pix_ready     = 1'b0;
      show          = 1'b0;
      underflow_set = 1'b0;
      misalign_set  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (ENABLE) state_d = ST_SEEK;
         end
         ST_SEEK: begin
            // Flush non-SOF words; hold an early SOF until origin.
            pix_ready = PIX_VALID && (!PIX_SOF || origin);
            if (PIX_VALID && PIX_SOF && origin) begin
               state_d = ST_LOCKED;
               show    = active;
            end
         end
         ST_LOCKED: begin
            pix_ready = active;
            if (active && !PIX_VALID) begin
               underflow_set = 1'b1;
               state_d       = ST_SEEK;
            end else if (active && PIX_SOF && !origin) begin
               misalign_set = 1'b1;
               state_d      = ST_SEEK;
            end else if (active) begin
               // Missing SOF at origin is flagged but the word is still shown.
               show         = 1'b1;
               misalign_set = !PIX_SOF && origin;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (!ENABLE) state_d = ST_IDLE;

      hs_d          = hs_pulse ? HS_POL : ~HS_POL;
      vs_d          = vs_pulse ? VS_POL : ~VS_POL;
      blank_d       = active;
      frame_start_d = origin;

      // Expansion fills 16 bits MSB-first; the top COLOR_W bits are kept.
      r_d = show ? COLOR_W'(rgb565_expand({1'b0, PIX_DATA[15:11]}, 5) >> (16 - COLOR_W)) : '0;
      g_d = show ? COLOR_W'(rgb565_expand(PIX_DATA[10:5], 6)         >> (16 - COLOR_W)) : '0;
      b_d = show ? COLOR_W'(rgb565_expand({1'b0, PIX_DATA[4:0]}, 5)  >> (16 - COLOR_W)) : '0;

      // Set has priority over clear.
      underflow_d = underflow_set || (underflow_q && !ERR_CLR);
      misalign_d  = misalign_set  || (misalign_q  && !ERR_CLR);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q       <= ST_IDLE;
         hs_q          <= ~HS_POL;
         vs_q          <= ~VS_POL;
         blank_q       <= 1'b0;
         frame_start_q <= 1'b0;
         r_q           <= '0;
         g_q           <= '0;
         b_q           <= '0;
         underflow_q   <= 1'b0;
         misalign_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         hs_q          <= hs_d;
         vs_q          <= vs_d;
         blank_q       <= blank_d;
         frame_start_q <= frame_start_d;
         r_q           <= r_d;
         g_q           <= g_d;
         b_q           <= b_d;
         underflow_q   <= underflow_d;
         misalign_q    <= misalign_d;
      end
   end

   assign PIX_READY   = pix_ready;
   assign VGA_HS      = hs_q;
   assign VGA_VS      = vs_q;
   assign VGA_BLANK   = blank_q;
   assign VGA_SYNC    = 1'b0;
   assign VGA_R       = r_q;
   assign VGA_G       = g_q;
   assign VGA_B       = b_q;
   assign FRAME_START = frame_start_q;
   assign LOCKED      = (state_q == ST_LOCKED);
   assign UNDERFLOW   = underflow_q;
   assign MISALIGN    = misalign_q;

endmodule

// File: tb/tb_vga_scanout.sv
// ---------------------------------------------------------------------------
// tb_vga_scanout
// Directed bench for vga_scanout on a 14x8 raster (8x4 visible).
// Each cycle the expected colour is queued when the inputs are driven and
// popped when the registered output appears; sync/blank/frame-start are
// checked every cycle against the bench's own raster position.
// ---------------------------------------------------------------------------
module tb_vga_scanout;

   localparam int HD = 8, VD = 4, HF = 2, HP = 3, HB = 1, VF = 1, VP = 2, VB = 1;
   localparam int HT = HD + HF + HP + HB;   // 14
   localparam int VT = VD + VF + VP + VB;   // 8
   localparam int CW = 10;

   typedef struct packed {
      logic [CW-1:0] r;
      logic [CW-1:0] g;
      logic [CW-1:0] b;
   } rgb_t;

   localparam rgb_t BLACK = '0;

   logic          CLK = 1'b0;
   logic          RST, ENABLE, PIX_SOF, PIX_VALID, ERR_CLR;
   logic [15:0]   PIX_DATA;
   logic          PIX_READY, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC;
   logic [CW-1:0] VGA_R, VGA_G, VGA_B;
   logic          FRAME_START, LOCKED, UNDERFLOW, MISALIGN;

   vga_scanout #(
      .HDISP(HD), .VDISP(VD), .HFP(HF), .HPULSE(HP), .HBP(HB),
      .VFP(VF), .VPULSE(VP), .VBP(VB),
      .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(CW)
   ) dut (
      .CLK(CLK), .RST(RST), .ENABLE(ENABLE),
      .PIX_DATA(PIX_DATA), .PIX_SOF(PIX_SOF), .PIX_VALID(PIX_VALID),
      .PIX_READY(PIX_READY),
      .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK(VGA_BLANK), .VGA_SYNC(VGA_SYNC),
      .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
      .FRAME_START(FRAME_START), .LOCKED(LOCKED),
      .UNDERFLOW(UNDERFLOW), .MISALIGN(MISALIGN), .ERR_CLR(ERR_CLR)
   );

   always #5 CLK = ~CLK;

   int   checks = 0;
   int   errors = 0;
   int   accepts = 0;
   int   bh = 0, bv = 0;     // raster position the next rising edge acts on
   rgb_t exp_q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic rgb_t expand(input logic [15:0] p);
      rgb_t e;
      e.r = {p[15:11], p[15:11]};
      e.g = {p[10:5],  p[10:7]};
      e.b = {p[4:0],   p[4:0]};
      return e;
   endfunction

   function automatic logic in_active(input int h, input int v);
      return (h < HD) && (v < VD);
   endfunction

   function automatic logic [15:0] pix_for(input int k);
      case (k)
         1:       return 16'h07E0;
         2:       return 16'h0841;
         3:       return 16'h001F;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic check_reset(input string tag);
      check({tag, "_hs"},    32'(VGA_HS),      32'd1);
      check({tag, "_vs"},    32'(VGA_VS),      32'd1);
      check({tag, "_blank"}, 32'(VGA_BLANK),   32'd0);
      check({tag, "_sync"},  32'(VGA_SYNC),    32'd0);
      check({tag, "_rgb"},   32'({VGA_R, VGA_G, VGA_B}), 32'd0);
      check({tag, "_fs"},    32'(FRAME_START), 32'd0);
      check({tag, "_lock"},  32'(LOCKED),      32'd0);
      check({tag, "_uf"},    32'(UNDERFLOW),   32'd0);
      check({tag, "_ma"},    32'(MISALIGN),    32'd0);
      check({tag, "_ready"}, 32'(PIX_READY),   32'd0);
   endtask

   // Called at a falling edge with inputs already driven.
   task automatic cycle(input rgb_t exp_pix, input logic exp_ready);
      int   ph, pv;
      rgb_t e, got;
      #1;
      check("pix_ready", 32'(PIX_READY), 32'(exp_ready));
      if (PIX_READY && PIX_VALID) accepts++;
      exp_q.push_back(exp_pix);
      ph = bh;
      pv = bv;
      @(posedge CLK);
      @(negedge CLK);
      check("hs",    32'(VGA_HS),    (ph >= HD + HF && ph < HD + HF + HP) ? 32'd0 : 32'd1);
      check("vs",    32'(VGA_VS),    (pv >= VD + VF && pv < VD + VF + VP) ? 32'd0 : 32'd1);
      check("blank", 32'(VGA_BLANK), in_active(ph, pv) ? 32'd1 : 32'd0);
      check("fs",    32'(FRAME_START), (ph == 0 && pv == 0) ? 32'd1 : 32'd0);
      check("sync",  32'(VGA_SYNC),  32'd0);
      e   = exp_q.pop_front();
      got = {VGA_R, VGA_G, VGA_B};
      check("rgb", 32'(got), 32'(e));
      bh++;
      if (bh == HT) begin
         bh = 0;
         bv = (bv + 1) % VT;
      end
   endtask

   task automatic feed(input logic valid, input logic sof, input logic [15:0] data,
                       input logic clr, input rgb_t exp_pix, input logic exp_ready);
      PIX_VALID = valid;
      PIX_SOF   = sof;
      PIX_DATA  = data;
      ERR_CLR   = clr;
      cycle(exp_pix, exp_ready);
   endtask

   task automatic locked_cycle(input logic [15:0] data, input logic sof);
      if (in_active(bh, bv)) feed(1'b1, sof, data, 1'b0, expand(data), 1'b1);
      else                   feed(1'b0, 1'b0, 16'h0, 1'b0, BLACK, 1'b0);
   endtask

   task automatic seek_cycle();
      if (in_active(bh, bv)) feed(1'b1, 1'b0, 16'($urandom), 1'b0, BLACK, 1'b1);
      else                   feed(1'b0, 1'b0, 16'h0, 1'b0, BLACK, 1'b0);
   endtask

   initial begin
      logic seeking;
      RST = 1'b1; ENABLE = 1'b0; PIX_DATA = '0; PIX_SOF = 1'b0;
      PIX_VALID = 1'b0; ERR_CLR = 1'b0;
      repeat (3) @(negedge CLK);
      check_reset("reset");
      RST = 1'b0;

      // Disabled: two frames of raster with a stream offered but never taken.
      for (int i = 0; i < 2 * HT * VT; i++) begin
         feed(1'b1, (i % 5) == 0, 16'($urandom), 1'b0, BLACK, 1'b0);
      end
      check("idle_lock", 32'(LOCKED), 32'd0);

      // Enable with red SOF held from before origin; taken only at origin.
      ENABLE  = 1'b1;
      accepts = 0;
      for (int i = 0; i < HT * VT; i++) feed(1'b1, 1'b1, 16'hF800, 1'b0, BLACK, 1'b0);
      check("sof_held", 32'(accepts), 32'd0);
      feed(1'b1, 1'b1, 16'hF800, 1'b0, expand(16'hF800), 1'b1);
      check("lock_at_origin", 32'(LOCKED), 32'd1);
      check("sof_red", 32'(VGA_R), 32'h3FF);

      // Continuous stream: rest of this frame, then one full frame.
      while (!(bh == 0 && bv == 0)) locked_cycle(pix_for(bv * HD + bh), 1'b0);
      check("accepts_f0", 32'(accepts), 32'd32);
      accepts = 0;
      do begin
         locked_cycle(pix_for(bv * HD + bh), bh == 0 && bv == 0);
      end while (!(bh == 0 && bv == 0));
      check("accepts_f1", 32'(accepts), 32'd32);
      check("stream_uf", 32'(UNDERFLOW), 32'd0);
      check("stream_ma", 32'(MISALIGN),  32'd0);
      check("stream_lock", 32'(LOCKED),  32'd1);

      // Underflow at (3,1), flush the remainder, relock at next origin.
      seeking = 1'b0;
      do begin
         if (bh == 3 && bv == 1) begin
            feed(1'b0, 1'b0, 16'h0, 1'b0, BLACK, 1'b1);
            check("uf_set",    32'(UNDERFLOW), 32'd1);
            check("uf_unlock", 32'(LOCKED),    32'd0);
            seeking = 1'b1;
         end else if (seeking) begin
            seek_cycle();
         end else begin
            locked_cycle(16'($urandom), bh == 0 && bv == 0);
         end
      end while (!(bh == 0 && bv == 0));
      locked_cycle(16'h07E0, 1'b1);
      check("uf_relock", 32'(LOCKED),    32'd1);
      check("uf_sticky", 32'(UNDERFLOW), 32'd1);
      feed(1'b1, 1'b0, 16'h1234, 1'b1, expand(16'h1234), 1'b1);
      check("uf_clr", 32'(UNDERFLOW), 32'd0);

      // SOF at (5,2) with a simultaneous clear: flag must still set.
      while (!(bh == 5 && bv == 2)) locked_cycle(16'($urandom), 1'b0);
      feed(1'b1, 1'b1, 16'hABCD, 1'b1, BLACK, 1'b1);
      check("ma_set",    32'(MISALIGN), 32'd1);
      check("ma_unlock", 32'(LOCKED),   32'd0);
      while (!(bh == 10 && bv == 7)) seek_cycle();
      while (!(bh == 0 && bv == 0)) feed(1'b1, 1'b1, 16'h001F, 1'b0, BLACK, 1'b0);
      feed(1'b1, 1'b1, 16'h001F, 1'b0, expand(16'h001F), 1'b1);
      check("ma_relock", 32'(LOCKED),   32'd1);
      check("ma_sticky", 32'(MISALIGN), 32'd1);
      feed(1'b1, 1'b0, 16'h5A5A, 1'b1, expand(16'h5A5A), 1'b1);
      check("ma_clr", 32'(MISALIGN), 32'd0);

      // Missing SOF at origin: shown, flagged, stays locked.
      while (!(bh == 0 && bv == 0)) locked_cycle(16'($urandom), 1'b0);
      feed(1'b1, 1'b0, 16'h0841, 1'b0, expand(16'h0841), 1'b1);
      check("nosof_ma",   32'(MISALIGN), 32'd1);
      check("nosof_lock", 32'(LOCKED),   32'd1);
      repeat (4) locked_cycle(16'($urandom), 1'b0);

      // Asynchronous reset between clock edges, mid-line.
      #2;
      RST = 1'b1;
      #1;
      check_reset("async_rst");
      ENABLE = 1'b0; PIX_VALID = 1'b0; PIX_SOF = 1'b0; ERR_CLR = 1'b0;
      repeat (2) @(negedge CLK);
      RST = 1'b0;
      bh  = 0;
      bv  = 0;
      feed(1'b0, 1'b0, 16'h0, 1'b0, BLACK, 1'b0);
      check("fs_after_rst", 32'(FRAME_START), 32'd1);
      repeat (20) feed(1'b0, 1'b0, 16'h0, 1'b0, BLACK, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
